// File: rtl/pll_dri_pkg.sv
// Shared types and constants for the PLL DRI master.
// Field widths, DRI command encodings, the completion-strobe index
// and the master FSM state enum.
package pll_dri_pkg;

    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 11;
    localparam int WDATA_W = 33;
    localparam int RDATA_W = 33;

    // Bit of DRI_RDATA that flags a completed access.
    localparam int CPL_BIT = 32;

    // Command field of DRI_CTRL.
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_WR   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_LOCKWAIT = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    // Even parity bit: makes the total number of ones (data + bit) even.
    function automatic logic even_parity(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/pll_dri_sync2.sv
// Two-flop synchronizer bringing the asynchronous PLL_LOCK into DRI_CLK.
// Both flops clear on the asynchronous active-low reset.
module pll_dri_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous level through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_dri_master.sv
// Fabric-side initiator for the PLL Dynamic Reconfiguration Interface.
// Accepts one read/write command at a time, drives DRI_CTRL/DRI_WDATA
// while the access is open, and returns a one-cycle response.
// Optional feature macro: PLL_DRI_LOCK_WAIT_EN -- when defined, writes wait
// for the PLL to relock (synchronized PLL_LOCK high 2 consecutive cycles)
// before responding, bounded by LOCK_WAIT_MAX cycles.
// Handshake: a command is taken on a clock edge where CMD_VALID and
// CMD_READY are both high; RSP_VALID is a single-cycle pulse with no
// backpressure, RSP_RDATA/RSP_ERR are meaningful only while it is high.
// DBG_STATE exposes the FSM state (pll_dri_pkg::state_e encoding).
module pll_dri_master
    import pll_dri_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LOCK_WAIT_MAX  = 4095
) (
    input  logic               DRI_CLK,
    input  logic               DRI_ARST_N,
    input  logic               CMD_VALID,
    output logic               CMD_READY,
    input  logic               CMD_WRITE,
    input  logic [ADDR_W-1:0]  CMD_ADDR,
    input  logic [DATA_W-1:0]  CMD_WDATA,
    output logic               RSP_VALID,
    output logic [DATA_W-1:0]  RSP_RDATA,
    output logic               RSP_ERR,
    output logic [CTRL_W-1:0]  DRI_CTRL,
    output logic [WDATA_W-1:0] DRI_WDATA,
    input  logic [RDATA_W-1:0] DRI_RDATA,
    input  logic               DRI_INTERRUPT,
    input  logic               PLL_LOCK,
    input  logic               IRQ_CLR,
    output logic               IRQ_PENDING,
    output logic [1:0]         DBG_STATE
);

    localparam logic [1:0] S_IDLE     = ST_IDLE;
    localparam logic [1:0] S_ACCESS   = ST_ACCESS;
    localparam logic [1:0] S_LOCKWAIT = ST_LOCKWAIT;
    localparam logic [1:0] S_RESP     = ST_RESP;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_ONE   = TW'(1);

    logic [1:0]         state_q,     state_d;
    logic               cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0]  cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0]  cmd_wdata_q, cmd_wdata_d;
    logic [TW-1:0]      tmo_cnt_q,   tmo_cnt_d;

    logic               cmd_ready_q, cmd_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;
    logic [CTRL_W-1:0]  dri_ctrl_q,  dri_ctrl_d;
    logic [WDATA_W-1:0] dri_wdata_q, dri_wdata_d;

    logic               irq_prev_q,  irq_prev_d;
    logic               irq_pend_q,  irq_pend_d;

    logic [DATA_W-1:0]  drive_data;

`ifdef PLL_DRI_LOCK_WAIT_EN
    localparam int LW = $clog2(LOCK_WAIT_MAX + 1);
    localparam logic [LW-1:0] LOCK_LIMIT = LW'(LOCK_WAIT_MAX);
    localparam logic [LW-1:0] LOCK_ONE   = LW'(1);

    logic               lock_sync;
    logic [LW-1:0]      lock_cnt_q,    lock_cnt_d;
    logic               lock_stable_q, lock_stable_d;

    pll_dri_sync2 u_lock_sync (
        .clk   (DRI_CLK),
        .rst_n (DRI_ARST_N),
        .d     (PLL_LOCK),
        .q     (lock_sync)
    );
`else
    logic unused_lock;
    assign unused_lock = PLL_LOCK ^ (LOCK_WAIT_MAX == 0);
`endif

    // FSM: command latch, DRI timeout, optional relock wait and response data.
    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        tmo_cnt_d   = tmo_cnt_q;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef PLL_DRI_LOCK_WAIT_EN
        lock_cnt_d    = lock_cnt_q;
        lock_stable_d = lock_stable_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    cmd_write_d = CMD_WRITE;
                    cmd_addr_d  = CMD_ADDR;
                    cmd_wdata_d = CMD_WDATA;
                    tmo_cnt_d   = '0;
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Completion is tested first so it wins over a same-cycle timeout.
                if (DRI_RDATA[CPL_BIT]) begin
                    if (cmd_write_q) begin
`ifdef PLL_DRI_LOCK_WAIT_EN
                        lock_cnt_d    = '0;
                        lock_stable_d = 1'b0;
                        state_d       = S_LOCKWAIT;
`else
                        state_d       = S_RESP;
`endif
                    end else begin
                        rsp_rdata_d = DRI_RDATA[DATA_W-1:0];
                        state_d     = S_RESP;
                    end
                end else if (tmo_cnt_q == TMO_LIMIT) begin
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_ONE;
                end
            end
            S_LOCKWAIT: begin
`ifdef PLL_DRI_LOCK_WAIT_EN
                // lock_stable_q remembers that lock was already high last cycle.
                lock_stable_d = lock_sync;
                if (lock_sync && lock_stable_q) begin
                    state_d = S_RESP;
                end else if (lock_cnt_q == LOCK_LIMIT) begin
                    rsp_err_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_ONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs are decoded from the next state so they line up
    // with the state they describe.
    always_comb begin
        drive_data  = cmd_write_d ? cmd_wdata_d : '0;
        cmd_ready_d = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_RESP);
        dri_ctrl_d  = '0;
        dri_wdata_d = '0;
        if (state_d == S_ACCESS) begin
            dri_ctrl_d  = {(cmd_write_d ? CMD_WR : CMD_RD), cmd_addr_d};
            dri_wdata_d = {even_parity(drive_data), drive_data};
        end
    end

    // Sticky interrupt flag: a rising edge sets it and beats a same-cycle clear.
    always_comb begin
        irq_prev_d = DRI_INTERRUPT;
        irq_pend_d = irq_pend_q;
        if (IRQ_CLR) begin
            irq_pend_d = 1'b0;
        end
        if (DRI_INTERRUPT && !irq_prev_q) begin
            irq_pend_d = 1'b1;
        end
    end

    // State, command and output registers.
    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            state_q     <= S_IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            tmo_cnt_q   <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            dri_ctrl_q  <= '0;
            dri_wdata_q <= '0;
            irq_prev_q  <= 1'b0;
            irq_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            dri_ctrl_q  <= dri_ctrl_d;
            dri_wdata_q <= dri_wdata_d;
            irq_prev_q  <= irq_prev_d;
            irq_pend_q  <= irq_pend_d;
        end
    end

`ifdef PLL_DRI_LOCK_WAIT_EN
    // Relock wait counter and stability flag.
    always_ff @(posedge DRI_CLK or negedge DRI_ARST_N) begin
        if (!DRI_ARST_N) begin
            lock_cnt_q    <= '0;
            lock_stable_q <= 1'b0;
        end else begin
            lock_cnt_q    <= lock_cnt_d;
            lock_stable_q <= lock_stable_d;
        end
    end
`endif

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign DRI_CTRL    = dri_ctrl_q;
    assign DRI_WDATA   = dri_wdata_q;
    assign IRQ_PENDING = irq_pend_q;
    assign DBG_STATE   = state_q;

endmodule

// File: doc/pll_dri_master.md
# pll_dri_master

Fabric-side initiator for the PLL Dynamic Reconfiguration Interface (DRI) of the clock-conditioning block. It accepts single read/write commands from a fabric controller, drives the DRI_CTRL/DRI_WDATA request bus, and collects completions from DRI_RDATA. It returns the result as a one-cycle response and tracks DRI_INTERRUPT as a sticky flag. It sits between the board-management logic and the PLL instance, replacing the tied-off DRI ports.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles from request issue to DRI completion before an error response.
- LOCK_WAIT_MAX, 4095: maximum cycles to wait for PLL relock after a write. Used only with the lock-wait feature.
- DRI_CLK  in  1  clock; the only clock in the block.
- DRI_ARST_N  in  1  reset, asynchronous assert, active-low.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted on the cycle where CMD_VALID & CMD_READY.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  9  DRI word address.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  one-cycle response pulse; there is no backpressure.
- RSP_RDATA  out  32  read data. It is 0 for writes and for errors.
- RSP_ERR  out  1  valid with RSP_VALID. Set on DRI timeout or lock timeout.
- DRI_CTRL  out  11  {cmd[1:0], addr[8:0]}. cmd: 00 idle, 01 read, 10 write.
- DRI_WDATA  out  33  {even parity of data, data[31:0]}.
- DRI_RDATA  in  33  bit 32 is the completion strobe; bits 31:0 carry the read data.
- DRI_INTERRUPT  in  1  level interrupt from the PLL.
- PLL_LOCK  in  1  PLL lock. It is asynchronous to DRI_CLK and is synchronized internally with 2 flops.
- IRQ_CLR  in  1  clears IRQ_PENDING.
- IRQ_PENDING  out  1  sticky interrupt flag.

## Operation
- State machine has four states: IDLE, ACCESS, LOCKWAIT, RESP.
- **IDLE**
  - CMD_READY = 1.
  - On accept, latch the command, clear the timeout counter, and go to ACCESS.
- **ACCESS**
  - DRI_CTRL and DRI_WDATA are driven from the latched command and held stable.
  - If DRI_RDATA[32] = 1:
    - capture DRI_RDATA[31:0] for reads;
    - writes go to LOCKWAIT (feature on) or RESP;
    - reads go to RESP.
  - Else, when the counter reaches TIMEOUT_CYCLES, set the error and go to RESP.
  - Completion and timeout in the same cycle: completion wins.
  - DRI_WDATA[31:0] = 0 for reads; DRI_WDATA[32] is the parity of the driven data bits.
- **LOCKWAIT**
  - Exit to RESP when the synchronized PLL_LOCK has been high for 2 consecutive cycles.
  - If LOCK_WAIT_MAX cycles elapse first, exit to RESP with the error set.
- **RESP**
  - RSP_VALID = 1 for exactly one cycle, then return to IDLE.
- DRI_CTRL = 0 and DRI_WDATA = 0 in every state except ACCESS.
- **IRQ_PENDING**
  - Set on a rising edge of DRI_INTERRUPT, detected with a registered previous value.
  - Cleared by IRQ_CLR.
  - A set and a clear in the same cycle: set wins.
- Counters saturate and never wrap. Counter widths are $clog2(param+1).
- CMD_VALID outside IDLE is ignored, because CMD_READY = 0.

## Timing
- Reset values:
  - CMD_READY = 0 during reset, then 1 on the first clock after deassertion.
  - RSP_VALID = 0, RSP_RDATA = 0, RSP_ERR = 0.
  - DRI_CTRL = 0, DRI_WDATA = 0.
  - IRQ_PENDING = 0.
  - State = IDLE; lock synchronizer = 0.
- All outputs are registered.
- Command accepted at cycle N: DRI_CTRL is valid at N+1.
- Completion sampled at cycle M:
  - DRI_CTRL = 0 at M+1;
  - for reads, or writes without lock wait, RSP_VALID at M+1.
- Minimum read latency, accept to RSP_VALID, is 3 cycles (completion at N+2 or later).
- No completion: RSP_VALID with RSP_ERR at N+1+TIMEOUT_CYCLES+1.
- Back-to-back commands: the next accept is possible in the cycle after RSP_VALID.
- Reset mid-access: the request is dropped immediately (DRI_CTRL = 0 asynchronously) and no response is emitted.
- A completion strobe arriving in IDLE or LOCKWAIT is ignored.

## Configuration
- PLL_DRI_LOCK_WAIT_EN defined:
  - writes pass through LOCKWAIT;
  - the PLL_LOCK synchronizer and the lock counter are present.
- PLL_DRI_LOCK_WAIT_EN undefined:
  - writes respond at M+1 like reads;
  - PLL_LOCK is unused and LOCK_WAIT_MAX has no effect.

## Structure
- Package pll_dri_pkg contains:
  - the state enum;
  - the DRI command encodings: CMD_IDLE = 2'b00, CMD_RD = 2'b01, CMD_WR = 2'b10;
  - field widths: address 9, data 32, ctrl 11, wdata/rdata 33;
  - the completion-bit index, 32.
- Sub-module pll_dri_sync2 implements the 2-flop PLL_LOCK synchronizer with asynchronous active-low reset.
- Everything else lives in pll_dri_master.

## Test plan
- **Read.** Read addr 9'h012; the responder returns 32'hCAFE_0001 with the strobe 3 cycles after issue.
  - Required: DRI_CTRL = 11'b01_000010010 held until the strobe cycle.
  - Required: RSP_VALID one cycle with RSP_RDATA = 32'hCAFE_0001 and RSP_ERR = 0.
- **Write.** Write addr 9'h003 with data 32'h0000_00FF.
  - Required: DRI_WDATA = 33'h0_0000_00FF, parity 0.
  - Required: RSP_RDATA = 0.
- **Write with lock wait (feature on).** PLL_LOCK drops and returns 20 cycles after the write completes.
  - Required: RSP_VALID no earlier than 2 sync + 2 stable cycles after PLL_LOCK rises.
  - Required: with PLL_LOCK held low, RSP_ERR = 1 after LOCK_WAIT_MAX.
- **DRI timeout.** Responder silent, TIMEOUT_CYCLES = 8, accept at cycle 10.
  - Required: RSP_VALID with RSP_ERR = 1 at cycle 20.
  - Required: DRI_CTRL = 0 from cycle 20.
- **Interrupt.** DRI_INTERRUPT rises in the same cycle IRQ_CLR is pulsed.
  - Required: IRQ_PENDING = 1 (set wins).
  - Required: a later IRQ_CLR alone gives IRQ_PENDING = 0.
- **Reset mid-access.** Assert DRI_ARST_N low during ACCESS.
  - Required: all outputs at reset values.
  - Required: a strobe arriving after reset release produces no RSP_VALID.
